// File: rtl/ram_byte_sequencer.sv
// Byte-serial load/store sequencer for the 4096 x 8 synchronous RAM (little-endian, 1/2/4 bytes).
// Optional macro RAM_ALIGN_CHECK_EN: reject misaligned half/word requests with err instead of accessing RAM.
module ram_byte_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [11:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        busy,
    output logic        err,
    output logic        ram_r_wn,
    output logic [11:0] ram_address,
    output logic [31:0] ram_data_in,
    input  logic [7:0]  ram_data_out
);

    typedef enum logic [2:0] {IDLE, WR, RD, RD_TAIL, RESP} state_t;

    state_t      state_q, state_d;
    logic [11:0] base_q, base_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  lastIdx_q, lastIdx_d;
    logic [2:0]  count_q, count_d;
    logic [31:0] readBuf_q, readBuf_d;
    logic [31:0] rdata_q, rdata_d;

    logic        misaligned;
    logic        writing;
    logic [1:0]  capIdx;
    logic [31:0] assembled;
    logic [31:0] extended;

`ifdef RAM_ALIGN_CHECK_EN
    logic errFlag_q, errFlag_d;

    assign misaligned = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
    assign errFlag_d  = (state_q == IDLE) ? (req && misaligned) : errFlag_q;

    always_ff @(posedge clk) begin
        if (!rst_n) errFlag_q <= 1'b0;
        else        errFlag_q <= errFlag_d;
    end

    assign err = done && errFlag_q;
`else
    assign misaligned = 1'b0;
    assign err        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            base_q    <= 12'd0;
            wdata_q   <= 32'd0;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            lastIdx_q <= 2'd0;
            count_q   <= 3'd0;
            readBuf_q <= 32'd0;
            rdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            wdata_q   <= wdata_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            lastIdx_q <= lastIdx_d;
            count_q   <= count_d;
            readBuf_q <= readBuf_d;
            rdata_q   <= rdata_d;
        end
    end

    // The final byte is still on ram_data_out during RD_TAIL, so it is merged in directly.
    assign capIdx = count_q[1:0] - 2'd1;

    always_comb begin
        assembled = readBuf_q;
        assembled[{lastIdx_q, 3'b000} +: 8] = ram_data_out;
        extended = assembled;
        case (size_q)
            2'b00:   extended = {{24{assembled[7] & ~uns_q}}, assembled[7:0]};
            2'b01:   extended = {{16{assembled[15] & ~uns_q}}, assembled[15:0]};
            default: extended = assembled;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        wdata_d   = wdata_q;
        size_d    = size_q;
        uns_d     = uns_q;
        lastIdx_d = lastIdx_q;
        count_d   = count_q;
        readBuf_d = readBuf_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    base_d    = addr;
                    wdata_d   = wdata;
                    size_d    = size;
                    uns_d     = uns;
                    lastIdx_d = (size == 2'b00) ? 2'd0 : ((size == 2'b01) ? 2'd1 : 2'd3);
                    count_d   = 3'd0;
                    if (misaligned)
                        state_d = RESP;
                    else if (we)
                        state_d = WR;
                    else
                        state_d = RD;
                end
            end
            WR: begin
                count_d = count_q + 3'd1;
                if (count_q[1:0] == lastIdx_q) state_d = RESP;
            end
            RD: begin
                if (count_q != 3'd0) readBuf_d[{capIdx, 3'b000} +: 8] = ram_data_out;
                count_d = count_q + 3'd1;
                if (count_q[1:0] == lastIdx_q) state_d = RD_TAIL;
            end
            RD_TAIL: begin
                rdata_d = extended;
                state_d = RESP;
            end
            RESP: begin
                count_d = 3'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Writes are gated by rst_n so the edge that aborts an access cannot also write a byte.
    assign writing     = (state_q == WR) && rst_n;
    assign ram_r_wn    = ~writing;
    assign ram_data_in = writing ? {24'd0, wdata_q[{count_q[1:0], 3'b000} +: 8]} : 32'd0;
    assign ram_address = (state_q == IDLE) ? base_q : (base_q + {9'd0, count_q});
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == RESP);
    assign rdata       = rdata_q;

endmodule

// File: tb/tb_ram_byte_sequencer.sv
// Self-checking bench for ram_byte_sequencer: behavioural RAM plus a byte-array reference model.
// Honours RAM_ALIGN_CHECK_EN the same way as the design.
module tb_ram_byte_sequencer;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        busy;
    logic        err;
    logic        ram_r_wn;
    logic [11:0] ram_address;
    logic [31:0] ram_data_in;
    logic [7:0]  ram_data_out;

    logic [7:0]  ram   [4096];
    logic [7:0]  model [4096];

    int          errors;
    int          checks;
    logic [31:0] expRdata;

    int          obsDoneCycle;
    int          obsBusyCycles;
    logic [31:0] obsWrMask;
    logic [31:0] obsRdata;
    logic        obsErr;
    logic        obsUpper;

`ifdef RAM_ALIGN_CHECK_EN
    localparam bit AlignCheck = 1'b1;
`else
    localparam bit AlignCheck = 1'b0;
`endif

    ram_byte_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .we           (we),
        .size         (size),
        .uns          (uns),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .done         (done),
        .busy         (busy),
        .err          (err),
        .ram_r_wn     (ram_r_wn),
        .ram_address  (ram_address),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] initByte(input int i);
        return 8'((i * 73 + 11) ^ (i >> 4));
    endfunction

    // Synchronous RAM with one-edge registered read
    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = initByte(i);
        forever begin
            @(posedge clk);
            if (!ram_r_wn) ram[ram_address] <= ram_data_in[7:0];
            ram_data_out <= ram[ram_address];
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int nBytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
    endfunction

    function automatic logic isMis(input logic [1:0] sz, input logic [1:0] lowAddr);
        return AlignCheck && (((sz == 2'b01) && lowAddr[0]) || (sz[1] && (lowAddr != 2'b00)));
    endfunction

    function automatic logic [31:0] modelLoad(input logic [1:0] sz, input logic u, input logic [11:0] a);
        logic [31:0] v;
        int n;
        v = 32'd0;
        n = nBytes(sz);
        for (int i = 0; i < n; i++) v = v | (32'(model[12'(a + 12'(i))]) << (8 * i));
        if (n == 1 && !u && v[7])  v = v | 32'hFFFF_FF00;
        if (n == 2 && !u && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic modelStore(input logic [1:0] sz, input logic [11:0] a, input logic [31:0] d);
        for (int i = 0; i < nBytes(sz); i++) model[12'(a + 12'(i))] = d[8 * i +: 8];
    endtask

    // Drives one request and records what the DUT did; ends in the IDLE cycle after done.
    task automatic runAccess(input logic w, input logic [1:0] sz, input logic u,
                             input logic [11:0] a, input logic [31:0] d);
        we = w; size = sz; uns = u; addr = a; wdata = d; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        obsDoneCycle = -1; obsBusyCycles = 0; obsWrMask = 32'd0;
        obsRdata = rdata; obsErr = 1'b0; obsUpper = 1'b0;
        for (int c = 1; c <= 20 && obsDoneCycle < 0; c++) begin
            if (!ram_r_wn) obsWrMask[c] = 1'b1;
            if (busy) obsBusyCycles++;
            if (ram_data_in[31:8] != 24'd0) obsUpper = 1'b1;
            if (done) begin
                obsDoneCycle = c;
                obsRdata = rdata;
                obsErr = err;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({rdata, done, busy, err, ram_r_wn, ram_address, ram_data_in} !==
            {32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 12'd0, 32'd0}) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h want %h",
                     {rdata, done, busy, err, ram_r_wn, ram_address, ram_data_in},
                     {32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 12'd0, 32'd0});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        expRdata = 32'd0;
    endtask

    task automatic test_word_store_load();
        runAccess(1'b1, 2'b10, 1'b0, 12'h100, 32'hDEAD_BEEF);
        modelStore(2'b10, 12'h100, 32'hDEAD_BEEF);
        checks++;
        if (obsDoneCycle !== 5) begin
            errors++; $display("[TB] FAIL wstore_done_cycle: got %0d want 5", obsDoneCycle);
        end
        checks++;
        if (obsWrMask !== 32'h0000_001E) begin
            errors++; $display("[TB] FAIL wstore_write_cycles: got %h want 0000001e", obsWrMask);
        end
        checks++;
        if ({ram[12'h103], ram[12'h102], ram[12'h101], ram[12'h100]} !== 32'hDEAD_BEEF) begin
            errors++;
            $display("[TB] FAIL wstore_ram: got %h want deadbeef",
                     {ram[12'h103], ram[12'h102], ram[12'h101], ram[12'h100]});
        end
        runAccess(1'b0, 2'b10, 1'b0, 12'h100, 32'd0);
        expRdata = 32'hDEAD_BEEF;
        checks++;
        if (obsRdata !== 32'hDEAD_BEEF) begin
            errors++; $display("[TB] FAIL wload_rdata: got %h want deadbeef", obsRdata);
        end
        checks++;
        if (obsDoneCycle !== 6 || obsBusyCycles !== 6) begin
            errors++;
            $display("[TB] FAIL wload_timing: done %0d busy %0d want 6 6", obsDoneCycle, obsBusyCycles);
        end
    endtask

    task automatic test_byte_sign();
        runAccess(1'b1, 2'b00, 1'b0, 12'h010, 32'h1234_5680);
        modelStore(2'b00, 12'h010, 32'h1234_5680);
        checks++;
        if (ram[12'h010] !== 8'h80 || ram[12'h011] !== model[12'h011]) begin
            errors++;
            $display("[TB] FAIL bstore_ram: got %h %h want 80 %h", ram[12'h010], ram[12'h011], model[12'h011]);
        end
        checks++;
        if (obsRdata !== expRdata) begin
            errors++; $display("[TB] FAIL bstore_rdata_kept: got %h want %h", obsRdata, expRdata);
        end
        runAccess(1'b0, 2'b00, 1'b0, 12'h010, 32'd0);
        checks++;
        if (obsRdata !== 32'hFFFF_FF80 || obsDoneCycle !== 3) begin
            errors++;
            $display("[TB] FAIL bload_signed: got %h cycle %0d want ffffff80 cycle 3", obsRdata, obsDoneCycle);
        end
        runAccess(1'b0, 2'b00, 1'b1, 12'h010, 32'd0);
        expRdata = 32'h0000_0080;
        checks++;
        if (obsRdata !== 32'h0000_0080) begin
            errors++; $display("[TB] FAIL bload_unsigned: got %h want 00000080", obsRdata);
        end
    endtask

    task automatic test_misaligned_wrap();
        runAccess(1'b1, 2'b01, 1'b0, 12'hFFF, 32'h0000_1234);
`ifdef RAM_ALIGN_CHECK_EN
        checks++;
        if (obsErr !== 1'b1 || obsDoneCycle !== 1 || obsWrMask !== 32'd0) begin
            errors++;
            $display("[TB] FAIL misaligned_reject: err %b cycle %0d wmask %h want 1 1 0",
                     obsErr, obsDoneCycle, obsWrMask);
        end
        checks++;
        if (ram[12'hFFF] !== model[12'hFFF] || ram[12'h000] !== model[12'h000] || obsRdata !== expRdata) begin
            errors++;
            $display("[TB] FAIL misaligned_untouched: ram %h %h rdata %h want %h %h %h",
                     ram[12'hFFF], ram[12'h000], obsRdata, model[12'hFFF], model[12'h000], expRdata);
        end
`else
        modelStore(2'b01, 12'hFFF, 32'h0000_1234);
        checks++;
        if (ram[12'hFFF] !== 8'h34 || ram[12'h000] !== 8'h12 || obsDoneCycle !== 3) begin
            errors++;
            $display("[TB] FAIL hstore_wrap: ram %h %h cycle %0d want 34 12 3",
                     ram[12'hFFF], ram[12'h000], obsDoneCycle);
        end
        runAccess(1'b0, 2'b01, 1'b1, 12'hFFF, 32'd0);
        expRdata = 32'h0000_1234;
        checks++;
        if (obsRdata !== 32'h0000_1234 || obsErr !== 1'b0) begin
            errors++; $display("[TB] FAIL hload_wrap: got %h err %b want 00001234 0", obsRdata, obsErr);
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic sawDone;
        sawDone = 1'b0;
        we = 1'b1; size = 2'b10; uns = 1'b0; addr = 12'h200; wdata = 32'hA1B2_C3D4; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (done) sawDone = 1'b1;
            if (c == 3) rst_n = 1'b0;
            @(posedge clk); #1;
        end
        checks++;
        if ({rdata, done, busy, err, ram_r_wn, ram_address, ram_data_in} !==
            {32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 12'd0, 32'd0}) begin
            errors++;
            $display("[TB] FAIL abort_outputs: got %h want %h",
                     {rdata, done, busy, err, ram_r_wn, ram_address, ram_data_in},
                     {32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 12'd0, 32'd0});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        if (done) sawDone = 1'b1;
        checks++;
        if (sawDone !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_no_done: done seen %b busy %b want 0 0", sawDone, busy);
        end
        checks++;
        if ({ram[12'h203], ram[12'h202], ram[12'h201], ram[12'h200]} !==
            {model[12'h203], model[12'h202], 8'hC3, 8'hD4}) begin
            errors++;
            $display("[TB] FAIL abort_ram: got %h want %h",
                     {ram[12'h203], ram[12'h202], ram[12'h201], ram[12'h200]},
                     {model[12'h203], model[12'h202], 8'hC3, 8'hD4});
        end
        model[12'h200] = 8'hD4;
        model[12'h201] = 8'hC3;
        expRdata = 32'd0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d, busyMask, doneMask, rdAtDone;
        d = $urandom;
        busyMask = 32'd0; doneMask = 32'd0; rdAtDone = 32'd0;
        we = 1'b1; size = 2'b10; uns = 1'b0; addr = 12'h300; wdata = d; req = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 14; c++) begin
            if (c == 1) we = 1'b0;
            if (c == 7) req = 1'b0;
            if (busy) busyMask[c] = 1'b1;
            if (done) begin
                doneMask[c] = 1'b1;
                if (c == 12) rdAtDone = rdata;
            end
            @(posedge clk); #1;
        end
        modelStore(2'b10, 12'h300, d);
        expRdata = modelLoad(2'b10, 1'b0, 12'h300);
        checks++;
        if (busyMask !== 32'h0000_1FBE || doneMask !== 32'h0000_1020) begin
            errors++;
            $display("[TB] FAIL b2b_timing: busy %h done %h want 00001fbe 00001020", busyMask, doneMask);
        end
        checks++;
        if (rdAtDone !== expRdata) begin
            errors++; $display("[TB] FAIL b2b_rdata: got %h want %h", rdAtDone, expRdata);
        end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] d, busyMask, doneMask;
        d = $urandom;
        busyMask = 32'd0; doneMask = 32'd0;
        we = 1'b1; size = 2'b10; uns = 1'b0; addr = 12'h340; wdata = d; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 2) begin req = 1'b1; we = 1'b0; addr = 12'h100; end
            if (c == 5) req = 1'b0;
            if (busy) busyMask[c] = 1'b1;
            if (done) doneMask[c] = 1'b1;
            @(posedge clk); #1;
        end
        modelStore(2'b10, 12'h340, d);
        checks++;
        if (busyMask !== 32'h0000_003E || doneMask !== 32'h0000_0020 || rdata !== expRdata) begin
            errors++;
            $display("[TB] FAIL busy_ignore: busy %h done %h rdata %h want 0000003e 00000020 %h",
                     busyMask, doneMask, rdata, expRdata);
        end
        checks++;
        if ({ram[12'h343], ram[12'h342], ram[12'h341], ram[12'h340]} !== d) begin
            errors++;
            $display("[TB] FAIL busy_ignore_ram: got %h want %h",
                     {ram[12'h343], ram[12'h342], ram[12'h341], ram[12'h340]}, d);
        end
    endtask

    task automatic test_random();
        logic        w, u, mis, upperSeen;
        logic [1:0]  sz;
        logic [11:0] a;
        logic [31:0] d;
        int          n, expDone, diffs;
        upperSeen = 1'b0;
        for (int t = 0; t < 40; t++) begin
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            u  = 1'($urandom_range(0, 1));
            a  = (t % 4 == 0) ? 12'(12'hFFC + $urandom_range(0, 3)) : 12'($urandom_range(0, 4095));
            d  = $urandom;
            n  = nBytes(sz);
            mis = isMis(sz, a[1:0]);
            if (!w && !mis) expRdata = modelLoad(sz, u, a);
            runAccess(w, sz, u, a, d);
            if (w && !mis) modelStore(sz, a, d);
            upperSeen = upperSeen | obsUpper;
            expDone = mis ? 1 : (w ? n + 1 : n + 2);
            checks++;
            if (obsDoneCycle !== expDone || obsBusyCycles !== expDone) begin
                errors++;
                $display("[TB] FAIL rand_timing[%0d]: done %0d busy %0d want %0d", t,
                         obsDoneCycle, obsBusyCycles, expDone);
            end
            checks++;
            if (obsWrMask !== ((w && !mis) ? (((32'd1 << n) - 32'd1) << 1) : 32'd0)) begin
                errors++; $display("[TB] FAIL rand_write_cycles[%0d]: got %h", t, obsWrMask);
            end
            checks++;
            if (obsRdata !== expRdata || obsErr !== mis) begin
                errors++;
                $display("[TB] FAIL rand_result[%0d]: rdata %h err %b want %h %b", t,
                         obsRdata, obsErr, expRdata, mis);
            end
        end
        checks++;
        if (upperSeen !== 1'b0) begin
            errors++; $display("[TB] FAIL ram_data_in_upper: nonzero upper bits seen %b want 0", upperSeen);
        end
        diffs = 0;
        for (int i = 0; i < 4096; i++) if (ram[i] !== model[i]) diffs++;
        checks++;
        if (diffs != 0) begin
            errors++; $display("[TB] FAIL ram_contents: %0d bytes differ, want 0", diffs);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        expRdata = 32'd0;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0;
        addr = 12'd0; wdata = 32'd0;
        for (int i = 0; i < 4096; i++) model[i] = initByte(i);
        test_reset();
        test_word_store_load();
        test_byte_sign();
        test_misaligned_wrap();
        test_reset_mid();
        test_back_to_back();
        test_busy_ignore();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
